// File: rtl/mem_responder.sv
// Word-addressed memory target for the multicycle CPU: one request at a time,
// programmable wait states, and misaligned / out-of-range error reporting.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        ack,
    output logic        busy,
    output logic        misaligned,
    output logic        out_of_range
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                mis_q, mis_d;
    logic                oor_q, oor_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         dout_q, dout_d;

    logic [31:0]         mem_q [DEPTH];

    logic                addr_mis_s;
    logic                addr_oor_s;
    logic                commit_s;
    logic                commit_wr_s;
    logic [ADDR_W-1:0]   commit_idx_s;
    logic [31:0]         commit_wdata_s;
    logic                mem_we_s;

    assign addr_mis_s = (Address[1:0] != 2'b00);
    assign addr_oor_s = |Address[31:ADDR_W+2];

    // Next-state, output and array-commit decode
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ack_d          = 1'b0;
        busy_d         = busy_q;
        mis_d          = mis_q;
        oor_d          = oor_q;
        wr_d           = wr_q;
        idx_d          = idx_q;
        wdata_d        = wdata_q;
        dout_d         = dout_q;
        commit_s       = 1'b0;
        commit_wr_s    = wr_q;
        commit_idx_s   = idx_q;
        commit_wdata_s = wdata_q;
        mem_we_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d    = Wr;
                    idx_d   = Address[ADDR_W+1:2];
                    wdata_d = Datain;
                    busy_d  = 1'b1;
                    if (addr_mis_s) begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        mis_d   = 1'b1;
                    end else if (addr_oor_s) begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        oor_d   = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero-wait access commits straight from the inputs
                        state_d        = ST_RESP;
                        ack_d          = 1'b1;
                        commit_s       = 1'b1;
                        commit_wr_s    = Wr;
                        commit_idx_s   = Address[ADDR_W+1:2];
                        commit_wdata_s = Datain;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    ack_d    = 1'b1;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                mis_d   = 1'b0;
                oor_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                mis_d   = 1'b0;
                oor_d   = 1'b0;
            end
        endcase

        if (commit_s && !commit_wr_s) begin
            dout_d = mem_q[commit_idx_s];
        end else begin
            dout_d = dout_d;
        end
        mem_we_s = commit_s && commit_wr_s;
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            mis_q   <= 1'b0;
            oor_q   <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= {ADDR_W{1'b0}};
            wdata_q <= 32'd0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            mis_q   <= mis_d;
            oor_q   <= oor_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
        end
    end

    // Word array: not reset, written only on entry to RESP for a valid write
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_q[commit_idx_s] <= commit_wdata_s;
        end
    end

    assign Dataout      = dout_q;
    assign ack          = ack_q;
    assign busy         = busy_q;
    assign misaligned   = mis_q;
    assign out_of_range = oor_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected responses are queued at issue
// time and retired against each ack pulse, including latency.
module tb_mem_responder;

    localparam int ADDR_W = 8;
    localparam int W      = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic        Wr    = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] Datain  = 32'd0;
    logic [31:0] Dataout;
    logic        ack;
    logic        busy;
    logic        misaligned;
    logic        out_of_range;

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .Wr           (Wr),
        .Address      (Address),
        .Datain       (Datain),
        .Dataout      (Dataout),
        .ack          (ack),
        .busy         (busy),
        .misaligned   (misaligned),
        .out_of_range (out_of_range)
    );

    typedef struct {
        string       tag;
        int          issue;
        int          lat;
        logic [31:0] dout;
        logic        mis;
        logic        oor;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [256];
    logic [31:0] model_dout = 32'd0;
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Retire one expected response per ack pulse
    always @(negedge clock) begin
        if (ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val({e.tag, ".lat"}, 32'(cyc - e.issue), 32'(e.lat));
                check_val({e.tag, ".dout"}, Dataout, e.dout);
                check_val({e.tag, ".mis"}, {31'd0, misaligned}, {31'd0, e.mis});
                check_val({e.tag, ".oor"}, {31'd0, out_of_range}, {31'd0, e.oor});
                check_val({e.tag, ".busy"}, {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check_val("ack_seen", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        @(negedge clock);
    endtask

    // Called at a negedge while the DUT is idle; intrude pokes a write while busy
    task automatic issue(input string tag, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit intrude);
        exp_t e;
        e.tag   = tag;
        e.issue = cyc;
        e.mis   = 1'b0;
        e.oor   = 1'b0;
        if (a[1:0] != 2'b00) begin
            e.lat = 1;
            e.mis = 1'b1;
        end else if (a[31:ADDR_W+2] != 22'd0) begin
            e.lat = 1;
            e.oor = 1'b1;
        end else begin
            e.lat = 1 + W;
            if (wr) model_mem[a[ADDR_W+1:2]] = d;
            else    model_dout = model_mem[a[ADDR_W+1:2]];
        end
        e.dout = model_dout;
        sb_q.push_back(e);
        req = 1'b1; Wr = wr; Address = a; Datain = d;
        @(negedge clock);
        if (intrude) begin
            Wr = 1'b1; Address = 32'h20; Datain = 32'h0BAD0BAD;
            @(negedge clock);
        end
        req = 1'b0; Wr = $urandom_range(1, 0) == 1; Address = $urandom; Datain = $urandom;
        wait_done();
    endtask

    initial begin
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_val("rst.ack", {31'd0, ack}, 32'd0);
            check_val("rst.busy", {31'd0, busy}, 32'd0);
            check_val("rst.dout", Dataout, 32'd0);
            check_val("rst.mis", {31'd0, misaligned}, 32'd0);
            check_val("rst.oor", {31'd0, out_of_range}, 32'd0);
        end
        req = 1'b0;
        reset = 1'b1;
        @(negedge clock);

        issue("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        issue("rd10", 1'b0, 32'h10, 32'h0, 1'b0);
        issue("mis13", 1'b0, 32'h13, 32'h0, 1'b0);
        issue("rd10b", 1'b0, 32'h10, 32'h0, 1'b0);

        issue("wr00", 1'b1, 32'h0, 32'h11111111, 1'b0);
        issue("oor400", 1'b1, 32'h400, 32'hCAFEF00D, 1'b0);
        issue("rd00", 1'b0, 32'h0, 32'h0, 1'b0);
        issue("mis401", 1'b1, 32'h401, 32'h12345678, 1'b0);

        issue("wr20", 1'b1, 32'h20, 32'h20202020, 1'b0);
        issue("busyrej", 1'b0, 32'h10, 32'h0, 1'b1);
        issue("rd20", 1'b0, 32'h20, 32'h0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = 32'h100 + 32'(i * 4);
            issue("rndwr", 1'b1, a, $urandom, 1'b0);
            issue("rndrd", 1'b0, a, 32'h0, 1'b0);
        end

        issue("wr24", 1'b1, 32'h24, 32'h24242424, 1'b0);
        req = 1'b1; Wr = 1'b1; Address = 32'h24; Datain = 32'hFFFF0000;
        @(negedge clock);
        req = 1'b0;
        reset = 1'b0;
        #1;
        check_val("midrst.busy", {31'd0, busy}, 32'd0);
        check_val("midrst.ack", {31'd0, ack}, 32'd0);
        check_val("midrst.dout", Dataout, 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        model_dout = 32'd0;
        @(negedge clock);
        repeat (4) begin
            @(negedge clock);
            check_val("postrst.ack", {31'd0, ack}, 32'd0);
        end
        issue("rd24", 1'b0, 32'h24, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
